cube_sched: RTL
===============

# cube_sched

Round-robin scheduler that shares one `cube532` cube datapath among `NUM_REQ` requesters. Each requester offers an 8-bit operand with a valid/ready handshake. The block grants at most one operand per cycle to the datapath and tracks the owner through the datapath's fixed latency. It returns each 24-bit cube to its owner as a one-hot response pulse. It sits between the requesting engines and the `cube532` instance; the instance is external and wired through `cube_in`/`cube_out`.

## Interface

Parameters:

- `NUM_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 2: cycles from `cube_in` sampled to `cube_out` valid; must match the datapath.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `sched_en` in 1: when low, no new grants; in-flight operations still complete.
- `req_valid` in `NUM_REQ`: requester i offers an operand.
- `req_data` in `NUM_REQ`×8: operand per requester, packed, requester i at bits `[8i+7:8i]`.
- `req_ready` out `NUM_REQ`: one-hot grant; the transfer occurs when `req_valid[i] & req_ready[i]`.
- `cube_in` out 8: operand to the datapath.
- `cube_out` in 24: result from the datapath.
- `resp_valid` out `NUM_REQ`: one-hot, one-cycle pulse; result for requester i.
- `resp_data` out 24: result, qualified by `resp_valid`.
- `inflight` out `$clog2(LATENCY+1)`: number of accepted operations not yet responded.

## Operation

- Grant logic is combinational in the current cycle.
  - `req_ready[i]` = 1 for exactly one i when `sched_en`, `!rst` and any `req_valid` is set; otherwise all zero.
  - `req_ready` never asserts for a requester whose `req_valid` is low.
- `cube_in` = `req_data` of the granted requester; 8'h00 when there is no grant.
- Tag pipeline: `LATENCY` stages of {valid, owner index}, shifted every cycle.
  - Stage 0 loads {1, granted index} on an accept and {0, x} otherwise.
- Response: when the last stage is valid, `resp_valid[owner]` = 1 and `resp_data` = `cube_out`, passed through combinationally. Otherwise `resp_valid` = 0 and `resp_data` = 0.
- Arbitration is round-robin over a pointer `last`, reset value `NUM_REQ-1`.
  - Search starts at `last+1` modulo `NUM_REQ` and wraps around.
  - `last` updates only on an accept.
- `inflight` = count of valid tag stages. An accept and a response in the same cycle leave the count unchanged.
- There is no response backpressure. A requester must always accept its `resp_valid` pulse.
- A requester may drop `req_valid` without a grant; no state is kept for it.

## Timing

- Throughput is one accept per cycle, sustained with no bubbles.
- An accept in cycle k produces `resp_valid` in cycle k+`LATENCY` (k+2 by default).
- Values while `rst` is high:
  - Outputs `req_ready`, `resp_valid`, `resp_data`, `cube_in` and `inflight` are all 0.
  - Tag stages are invalid.
  - `last` = `NUM_REQ-1`.
- Reset mid-operation: in-flight operations are discarded and no `resp_valid` appears for them. The first accept after reset goes to the lowest-index active requester.
- `sched_en` falling: grants stop in the same cycle. Responses still emerge `LATENCY` cycles after their accepts.

## Configuration

- `CUBE_SCHED_RR_EN` defined: round-robin arbitration as described.
- Not defined: fixed priority. The lowest-index valid requester always wins and the `last` register is not built. Starvation of higher indices is permitted.

## Structure

- `cube_sched_pkg` holds:
  - constants `CUBE_DATA_W` = 8, `CUBE_RES_W` = 24, `CUBE_LATENCY` = 2;
  - the `tag_t` struct {valid, owner index};
  - the default `NUM_REQ`.
- Sub-module `cube_rr_arbiter`: request vector in, one-hot grant out, with a pointer update on an `accept` input. It contains the `CUBE_SCHED_RR_EN` switch.
- The top level contains the operand mux, tag shift register, response demux and `inflight` counter.

## Test plan

- Single request: requester 1 offers 8'd3 → `req_ready` = 4'b0010 in the same cycle; 2 cycles later `resp_valid` = 4'b0010 and `resp_data` = 24'd27.
- All four requesters held valid with operands 1, 2, 3, 4 → grants 0, 1, 2, 3, 0, … on consecutive cycles; responses 1, 8, 27, 64 in the same order, each 2 cycles after its grant.
- Back-to-back sweep: requester 0 streams 0..255 continuously → `resp_data` = i³ every cycle (255 → 24'd16581375); `inflight` holds at 2.
- Reset mid-stream: assert `rst` for 1 cycle with 2 operations in flight → no `resp_valid` for them; `inflight` = 0; the next grant goes to requester 0.
- `sched_en` low with requesters valid → `req_ready` = 0 and `cube_in` = 0; earlier accepts still respond, and `inflight` falls to 0.
- Without `CUBE_SCHED_RR_EN`: requesters 0 and 2 held valid → requester 0 is granted every cycle and requester 2 is never granted.

Source files
------------

// File: rtl/cube_sched_pkg.sv
// rtl/cube_sched_pkg.sv - shared constants and types for the cube_sched scheduler
//
// Purpose : widths, datapath latency and the owner-tag type used by the
//           scheduler top level and its round-robin arbiter.
// Ports   : none (package).
// Config  : CUBE_SCHED_RR_EN selects round-robin arbitration in cube_rr_arbiter;
//           without it the arbiter is fixed priority (lowest index wins).

package cube_sched_pkg;

  localparam int CUBE_DATA_W  = 8;   // operand width
  localparam int CUBE_RES_W   = 24;  // cube result width (255^3 fits in 24 bits)
  localparam int CUBE_LATENCY = 2;   // cube datapath latency in cycles
  localparam int CUBE_NUM_REQ = 4;   // default requester count

  // Owner field is sized for the largest supported requester count (8).
  localparam int CUBE_OWNER_W = 3;

  typedef struct packed {
    logic                    valid;
    logic [CUBE_OWNER_W-1:0] owner;
  } tag_t;

endpackage

// File: rtl/cube_rr_arbiter.sv
// rtl/cube_rr_arbiter.sv - one-hot grant arbiter, round-robin or fixed priority
//
// Purpose : picks exactly one requester from req_i each cycle (combinationally).
// Ports   : clk, rst       - clock, asynchronous active-high reset
//           req_i          - eligible request vector (already gated by enable)
//           accept_i       - a grant was taken this cycle; advances the pointer
//           grant_o        - one-hot grant, zero when req_i is zero
//           grant_idx_o    - binary index of the granted requester
// Config  : CUBE_SCHED_RR_EN defined -> round-robin with pointer last_q
//           (reset NUM_REQ-1, so the first search begins at index 0).
//           undefined -> fixed priority, lowest index wins, no pointer built.

module cube_rr_arbiter
  import cube_sched_pkg::*;
#(
  parameter int NUM_REQ = CUBE_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

`ifdef CUBE_SCHED_RR_EN

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;

  // Search begins one past the last winner and wraps, so every active
  // requester is served within NUM_REQ accepts.
  always_comb begin
    int               idx;
    logic             found;
    logic [IDX_W-1:0] idx_l;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    idx_l       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_l = IDX_W'(idx);
      if (!found && req_i[idx_l]) begin
        found          = 1'b1;
        grant_o[idx_l] = 1'b1;
        grant_idx_o    = idx_l;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = grant_idx_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

`else

  // Fixed priority: the pointer does not exist, so clock/reset/accept are
  // intentionally unused here.
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, accept_i};

  always_comb begin
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = IDX_W'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/cube_sched.sv
// rtl/cube_sched.sv - shares one external cube datapath among NUM_REQ requesters
//
// Purpose : grants at most one operand per cycle to the cube datapath, tracks
//           the owner through the datapath latency and returns each result
//           to its owner as a one-hot pulse.
// Ports   : clk, rst    - clock, asynchronous active-high reset
//           sched_en    - low blocks new grants; in-flight work still completes
//           req_valid   - per-requester operand offer
//           req_data    - packed operands, requester i at [8i+7:8i]
//           req_ready   - one-hot combinational grant
//           cube_in     - operand to the datapath (0 without a grant)
//           cube_out    - datapath result, valid LATENCY cycles after cube_in
//           resp_valid  - one-hot one-cycle response pulse
//           resp_data   - result qualified by resp_valid (0 otherwise)
//           inflight    - accepted operations not yet responded
// Config  : CUBE_SCHED_RR_EN (in cube_rr_arbiter) selects round-robin;
//           default build is fixed priority.

module cube_sched
  import cube_sched_pkg::*;
#(
  parameter int NUM_REQ = CUBE_NUM_REQ,
  parameter int LATENCY = CUBE_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sched_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*CUBE_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [CUBE_DATA_W-1:0]         cube_in,
  input  logic [CUBE_RES_W-1:0]          cube_out,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [CUBE_RES_W-1:0]          resp_data,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0] req_eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic               resp_fire;

  tag_t tag_q [LATENCY];
  tag_t tag_d [LATENCY];

  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  // Gating at the arbiter input makes grants vanish in the same cycle that
  // sched_en falls or rst rises.
  assign req_eligible = (sched_en && !rst) ? req_valid : '0;

  cube_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_eligible),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);

  // One-hot AND-OR operand mux; zero when nothing is granted.
  always_comb begin
    cube_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cube_in = cube_in | (req_data[i*CUBE_DATA_W +: CUBE_DATA_W] & {CUBE_DATA_W{grant[i]}});
    end
  end

  // Owner tags travel alongside the operand through the datapath so the
  // last stage lines up with cube_out.
  always_comb begin
    tag_d[0].valid = accept;
    tag_d[0].owner = accept ? CUBE_OWNER_W'(grant_idx) : '0;
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign resp_fire = tag_q[LATENCY-1].valid;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resp_fire && (tag_q[LATENCY-1].owner == CUBE_OWNER_W'(i))) begin
        resp_valid[i] = 1'b1;
      end
    end
  end

  assign resp_data = resp_fire ? cube_out : '0;

  // Equals the number of valid tag stages; accept and response together
  // cancel out.
  assign inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;

endmodule
